// File: rtl/hex_print_fmt.sv
// rtl/hex_print_fmt.sv - print request to ASCII character stream formatter
// Hex digits MS first with optional group separators, then a mode-selected terminator.
module hex_print_fmt #(
  parameter int          DATA_W   = 32,
  parameter int          GROUP    = 4,
  parameter logic [7:0]  SEP_CHAR = 8'h5F,
  parameter logic [7:0]  END_CHAR = 8'h20,
  parameter int          UPPER    = 1,
  parameter int          NIB_W    = $clog2(DATA_W/4)+1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        mode,
  input  logic [NIB_W-1:0]  n_nib,
  input  logic              req_tx,
  output logic              ack_tx,
  output logic              busy,
  output logic [7:0]        d_tx,
  output logic              vld_tx,
  input  logic              rdy_tx
);
  localparam int               DIGITS   = DATA_W/4;
  localparam int               GDIV     = (GROUP == 0) ? 1 : GROUP;
  localparam logic [NIB_W-1:0] DIGITS_N = NIB_W'(DIGITS);

  typedef enum logic [1:0] {IDLE, SEND, ACK} state_t;
  typedef enum logic [2:0] {PH_RAW, PH_DIG, PH_SEP, PH_T1, PH_T2} phase_t;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10)
      return 8'h30 + {4'h0, nib};
    return ((UPPER != 0) ? 8'h41 : 8'h61) + {4'h0, nib} - 8'd10;
  endfunction

  function automatic logic [3:0] nib_of(input logic [DATA_W-1:0] w, input logic [NIB_W-1:0] i);
    logic [DATA_W-1:0] s;
    s = w >> {i, 2'b00};
    return s[3:0];
  endfunction

  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              crlf_q, crlf_d;
  logic [NIB_W-1:0]  idx_q, idx_d;
  logic [7:0]        d_tx_q, d_tx_d;
  logic              vld_q, vld_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;

  logic [NIB_W-1:0]  n_clamp, first_idx, idx_m1;
  logic              sep_after;
  logic              done;

  assign n_clamp   = (n_nib == '0 || n_nib > DIGITS_N) ? DIGITS_N : n_nib;
  assign first_idx = n_clamp - 1'b1;
  assign idx_m1    = idx_q - 1'b1;
  // idx_q is the nibble just presented; a separator follows it on group boundaries
  assign sep_after = (GROUP != 0) && (idx_q != '0) && ((32'(idx_q) % GDIV) == 0);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    data_d  = data_q;
    crlf_d  = crlf_q;
    idx_d   = idx_q;
    d_tx_d  = d_tx_q;
    vld_d   = vld_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_tx) begin
          data_d  = din;
          crlf_d  = (mode == 2'd2);
          busy_d  = 1'b1;
          vld_d   = 1'b1;
          state_d = SEND;
          if (mode == 2'd1 || mode == 2'd2) begin
            phase_d = PH_DIG;
            idx_d   = first_idx;
            d_tx_d  = hex_char(nib_of(din, first_idx));
          end else begin
            phase_d = PH_RAW;
            idx_d   = '0;
            d_tx_d  = din[7:0];
          end
        end
      end
      SEND: begin
        if (vld_q && rdy_tx) begin
          case (phase_q)
            PH_DIG: begin
              if (sep_after) begin
                phase_d = PH_SEP;
                d_tx_d  = SEP_CHAR;
              end else if (idx_q != '0) begin
                idx_d  = idx_m1;
                d_tx_d = hex_char(nib_of(data_q, idx_m1));
              end else begin
                phase_d = PH_T1;
                d_tx_d  = crlf_q ? 8'h0D : END_CHAR;
              end
            end
            PH_SEP: begin
              phase_d = PH_DIG;
              idx_d   = idx_m1;
              d_tx_d  = hex_char(nib_of(data_q, idx_m1));
            end
            PH_T1: begin
              if (crlf_q) begin
                phase_d = PH_T2;
                d_tx_d  = 8'h0A;
              end else begin
                done = 1'b1;
              end
            end
            default: done = 1'b1;
          endcase
          if (done) begin
            vld_d   = 1'b0;
            ack_d   = 1'b1;
            state_d = ACK;
          end
        end
      end
      ACK: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      phase_q <= PH_RAW;
      data_q  <= '0;
      crlf_q  <= 1'b0;
      idx_q   <= '0;
      d_tx_q  <= 8'h00;
      vld_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      crlf_q  <= crlf_d;
      idx_q   <= idx_d;
      d_tx_q  <= d_tx_d;
      vld_q   <= vld_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign ack_tx = ack_q;
  assign busy   = busy_q;
  assign d_tx   = d_tx_q;
  assign vld_tx = vld_q;

endmodule

// File: tb/tb_hex_print_fmt.sv
// tb/tb_hex_print_fmt.sv - randomized bench for hex_print_fmt against a queue-based model
module tb_hex_print_fmt;
  localparam int         DW   = 32;
  localparam int         GRP  = 4;
  localparam logic [7:0] SEP  = 8'h5F;
  localparam logic [7:0] ENDC = 8'h20;
  localparam int         UP   = 1;
  localparam int         NW   = $clog2(DW/4)+1;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] din;
  logic [1:0]    mode;
  logic [NW-1:0] n_nib;
  logic          req_tx;
  logic          ack_tx;
  logic          busy;
  logic [7:0]    d_tx;
  logic          vld_tx;
  logic          rdy_tx;

  int n_chk = 0;
  int n_bad = 0;

  hex_print_fmt #(
    .DATA_W(DW), .GROUP(GRP), .SEP_CHAR(SEP), .END_CHAR(ENDC), .UPPER(UP)
  ) dut (
    .clk(clk), .rstn(rstn), .din(din), .mode(mode), .n_nib(n_nib),
    .req_tx(req_tx), .ack_tx(ack_tx), .busy(busy), .d_tx(d_tx),
    .vld_tx(vld_tx), .rdy_tx(rdy_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef logic [7:0] cq_t[$];

  function automatic cq_t model(input logic [31:0] d, input logic [1:0] m, input int nn);
    cq_t q;
    int  n;
    int  dig;
    if (m == 2'd1 || m == 2'd2) begin
      n = (nn == 0 || nn > DW/4) ? DW/4 : nn;
      for (int i = n-1; i >= 0; i--) begin
        dig = int'((d >> (4*i)) & 32'hF);
        q.push_back(dig < 10 ? 8'(48 + dig) : 8'(((UP != 0) ? 65 : 97) + dig - 10));
        if (GRP != 0 && i > 0 && (i % GRP) == 0) q.push_back(SEP);
      end
      if (m == 2'd1) q.push_back(ENDC);
      else begin
        q.push_back(8'h0D);
        q.push_back(8'h0A);
      end
    end else begin
      q.push_back(d[7:0]);
    end
    return q;
  endfunction

  task automatic run_txn(input logic [31:0] d, input logic [1:0] m, input logic [NW-1:0] nn,
                         input int bp, input bit hold_req, input logic [31:0] nxt_din);
    cq_t        exp_q;
    int         nchars;
    int         cyc;
    bit         acked;
    bit         stalled;
    logic [7:0] prev_d;
    exp_q  = model(d, m, int'(nn));
    nchars = exp_q.size();
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_vld", vld_tx, 0);
    chk("idle_ack", ack_tx, 0);
    din = d; mode = m; n_nib = nn; req_tx = 1'b1; rdy_tx = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_req) req_tx = 1'b0;
    din   = nxt_din;
    mode  = 2'($urandom);
    n_nib = NW'($urandom);
    cyc = 0; acked = 0; stalled = 0; prev_d = 8'h00;
    while (!acked && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ack_tx) begin
        acked = 1;
        chk("ack_vld", vld_tx, 0);
        chk("ack_busy", busy, 1);
        chk("ack_left", exp_q.size(), 0);
        if (bp == 0) chk("ack_cyc", cyc, nchars + 1);
      end else begin
        chk("busy", busy, 1);
        if (stalled) begin
          chk("hold_vld", vld_tx, 1);
          chk("hold_d", d_tx, prev_d);
        end
        if (bp == 0 && cyc <= nchars) chk("nobubble", vld_tx, 1);
        rdy_tx = ($urandom_range(99) >= bp);
        stalled = 0;
        if (vld_tx) begin
          if (rdy_tx) begin
            if (exp_q.size() == 0) chk("extra_char", vld_tx, 0);
            else chk("char", d_tx, exp_q.pop_front());
          end else begin
            stalled = 1;
            prev_d  = d_tx;
          end
        end
      end
    end
    if (!acked) chk("timeout", acked, 1);
  endtask

  initial begin
    rstn = 1'b0; din = '0; mode = '0; n_nib = '0; req_tx = 1'b0; rdy_tx = 1'b1;
    #1;
    chk("rst_ack", ack_tx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vld", vld_tx, 0);
    chk("rst_d", d_tx, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    run_txn(32'h0000_0041, 2'd0, 4'd0, 0, 0, $urandom);
    run_txn(32'hDEAD_BEEF, 2'd1, 4'd0, 0, 0, $urandom);
    run_txn(32'h1234_5ABC, 2'd2, 4'd3, 0, 0, $urandom);
    run_txn(32'h1234_5ABC, 2'd2, 4'd9, 0, 0, $urandom);
    run_txn(32'h89AB_CD57, 2'd3, 4'd5, 0, 0, $urandom);
    repeat (3) run_txn(32'hDEAD_BEEF, 2'd1, 4'd0, 50, 0, $urandom);

    // abort mid-print with asynchronous reset
    @(negedge clk);
    din = 32'hDEAD_BEEF; mode = 2'd1; n_nib = 4'd0; req_tx = 1'b1; rdy_tx = 1'b1;
    @(posedge clk);
    #1 req_tx = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("abort_vld", vld_tx, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack_tx, 0);
    chk("abort_d", d_tx, 0);
    @(negedge clk);
    chk("abort_ack2", ack_tx, 0);
    rstn = 1'b1;
    run_txn(32'hDEAD_BEEF, 2'd1, 4'd0, 0, 0, $urandom);

    // request held through ack; second print must use the fresh din
    run_txn(32'hCAFE_F00D, 2'd1, 4'd5, 0, 1, 32'h1357_9BDF);
    run_txn(32'h1357_9BDF, 2'd2, 4'd0, 0, 0, $urandom);

    for (int k = 0; k < 40; k++)
      run_txn($urandom, 2'($urandom), NW'($urandom), (k % 2) ? 40 : 0, 0, $urandom);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/hex_print_fmt.md
Name: hex_print_fmt

Overview:
- Parametrised successor to the serial-debug print formatter.
- Accepts one print request per handshake and converts a latched data word into an ASCII character stream for the UART transmitter.
- Output modes: raw byte, grouped hex with a terminator char, or grouped hex with CR/LF.
- Width, digit count, grouping, separator, terminator and hex case are configurable. The output side is a standard valid/ready stream.

Parameters:
- DATA_W, 32: input word width; must be a multiple of 4, range 8..64.
- GROUP, 4: nibbles per separator group; 0 disables separators.
- SEP_CHAR, 8'h5F: separator character ('_').
- END_CHAR, 8'h20: terminator character for mode 1 (' ').
- UPPER, 1: 1 selects hex digits 'A'-'F'; 0 selects 'a'-'f'.
- NIB_W, $clog2(DATA_W/4)+1: derived width of n_nib; do not override.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- din  in  DATA_W  data to print; sampled only at acceptance
- mode  in  2  0 = raw byte din[7:0]; 1 = hex + END_CHAR; 2 = hex + 0x0D 0x0A; 3 = behaves as mode 0
- n_nib  in  NIB_W  hex digits to print; 0, or any value > DATA_W/4, means DATA_W/4
- req_tx  in  1  print request, level
- ack_tx  out  1  one-cycle done pulse
- busy  out  1  high from the cycle after acceptance through the ack cycle
- d_tx  out  8  character to the transmitter
- vld_tx  out  1  d_tx valid
- rdy_tx  in  1  transmitter ready

Behaviour:
- Reset (async, immediate): ack_tx=0, busy=0, vld_tx=0, d_tx=8'h00, state IDLE, all counters 0. A reset mid-transaction abandons it; no ack is issued.
- States: IDLE, SEND, ACK.
- IDLE:
  - If req_tx=1 at a rising edge: latch din, mode and the clamped n_nib (N); reset the character index; go to SEND.
  - The first character is driven with vld_tx=1 in the next cycle (latency 1).
- Hex character sequence, N digits:
  - Digits are emitted for nibble i = N-1 down to 0, MS first.
  - After emitting nibble i, if GROUP!=0 and i>0 and i%GROUP==0, emit SEP_CHAR.
  - Then the terminator: END_CHAR (mode 1) or 0x0D then 0x0A (mode 2).
- Mode 0/3 sequence: exactly one char, din[7:0] unmodified.
- SEND handshake:
  - A transfer occurs at any edge with vld_tx=1 and rdy_tx=1.
  - d_tx is held stable while vld_tx=1 and rdy_tx=0.
  - The next char is presented in the cycle after a transfer, with no bubble, so sustained throughput is 1 char/clk when rdy_tx stays high.
  - vld_tx never depends combinationally on rdy_tx.
- Last transfer: vld_tx drops the next cycle; state moves to ACK.
- ACK:
  - ack_tx=1 and busy=1 for exactly one cycle, vld_tx=0; then IDLE.
  - The requester must drop req_tx on seeing ack_tx. If req_tx is still high in the following IDLE cycle, a new transaction starts with fresh din.
- Ignored inputs: changes to din, mode or n_nib after acceptance have no effect. req_tx is ignored outside IDLE.
- Hex conversion: 0-9 map to 0x30-0x39; A-F map to 0x41-0x46 (UPPER=1) or 0x61-0x66 (UPPER=0).
- Character counter must cover the worst case: DATA_W/4 digits + separators + 2 terminator chars.

Test Plan:
1. DATA_W=32, mode=0, din=0x00000041, rdy_tx=1, req at edge T -> single 0x41 in cycle T+1; ack_tx in cycle T+2; busy high T+1..T+2.
2. mode=1, n_nib=0, din=0xDEADBEEF, rdy_tx=1 -> 44 45 41 44 5F 42 45 45 46 20 on cycles T+1..T+10; ack at T+11. With UPPER=0, the letter codes become 0x64/0x65/0x61/0x62/0x66.
3. mode=2, n_nib=3, din=0x12345ABC -> 41 42 43 0D 0A with no separator; n_nib=9 -> clamped to 8 digits: "1234_5ABC" then 0D 0A.
4. Random rdy_tx backpressure (about 50%) on scenario 2 -> identical char sequence, d_tx stable whenever vld&&!rdy, no dropped or duplicated chars, ack after the 10th transfer.
5. rstn low after 3 transfers -> all outputs 0 immediately, no ack; new request after reset prints the full sequence from the first char.
6. req_tx held high across ack with din changed mid-transaction -> first print uses the originally latched value; second transaction starts in the cycle after ack returns to IDLE, using the new din.
